rs_correct: RTL
===============

Name: rs_correct

Overview:
- Downstream companion to the RS decoder. Buffers each received symbol stream in a circular delay RAM while the decoder works on it.
- When the decoder presents its per-symbol error pattern, the block reads back the matching buffered symbol, XORs the error into it and emits the corrected symbol with codeword framing.
- Reports per-codeword correction counts and sticky buffer fault flags.

Parameters:
- ADDR_W, 10, delay RAM address width; depth = 2**ADDR_W symbols.
- NPAR, 4, parity symbols per codeword (matches the decoder's syndrome count); n = k + NPAR.

Ports:
- clk  in  1  clock, all state on rising edge
- clr  in  1  synchronous active-high reset
- k  in  8  data symbols per codeword, sampled at codeword start on output side
- x  in  8  received symbol (same stream as decoder input)
- enable  in  1  x valid this cycle
- err  in  8  decoder error pattern symbol
- err_valid  in  1  err valid this cycle (decoder valid)
- y  out  8  corrected symbol
- y_valid  out  1  y valid
- y_sop  out  1  first symbol of codeword, with y_valid
- y_eop  out  1  last symbol (index n-1), with y_valid
- y_parity  out  1  symbol index >= k, with y_valid
- cw_errs  out  8  count of nonzero err symbols in codeword just finished
- cw_done  out  1  one-cycle pulse coincident with y_eop
- level  out  ADDR_W+1  buffered symbols not yet consumed
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: err_valid while empty

Behaviour:
- Reset (clr high at an edge) clears wr_ptr, rd_ptr, level, the output symbol index, and the running error count. It also drives y_valid, y_sop, y_eop, y_parity, cw_done, overflow and underflow to 0, and y and cw_errs to 0. RAM contents are not cleared.
- Reset mid-codeword discards all buffered data; the first err_valid after reset is index 0.

Write side:
- enable & ~full: mem[wr_ptr] <= x and wr_ptr increments, wrapping modulo 2**ADDR_W.
- enable & full: write is dropped and overflow is set.

Read side:
- err_valid & ~empty: read mem[rd_ptr] and increment rd_ptr (wrapping).
- Registered output, latency exactly 1: on the next cycle y = mem[rd_ptr_old] ^ err_registered and y_valid = 1.
- err_valid & empty: underflow is set and rd_ptr is held. y_valid still pulses with y = err (buffer treated as 0) so output framing is not lost.

level:
- Increments on an accepted write only, decrements on an accepted read only, unchanged when both occur in the same cycle.
- full = (level == 2**ADDR_W), empty = (level == 0).
- When level == 0, a write and err_valid in the same cycle count as underflow: the read uses the old empty state, with no bypass.

Framing counter idx, 8 bits, advances on each err_valid:
- idx == 0: latch k into k_cw and assert y_sop.
- y_parity = (idx >= k_cw); y_eop = (idx == k_cw + NPAR - 1), computed in 9 bits.
- After eop, idx returns to 0.
- k changes mid-codeword are ignored until the next idx == 0.

Error counting:
- The running count increments when err != 0 on an accepted err_valid; it saturates at 255.
- At eop: cw_errs <= running count including the current symbol, cw_done pulses, and the running count clears. cw_errs holds until the next eop.
- Flags clear only by clr.

Optional Feature:
- Macro RS_CORRECT_STATS_EN. When defined, three extra outputs are added:
  - stat_cw (32b): codewords completed.
  - stat_err_cw (32b): codewords with cw_errs != 0.
  - stat_sym (32b): total nonzero err symbols.
- All three are cleared by clr, update on the cycle cw_done is asserted, and saturate at all-ones.
- When the macro is undefined, these ports and registers do not exist and the other behaviour is identical.

Test Plan:
- Clean codeword: k=8, write 12 symbols 0x01..0x0C, then 12 err_valid with err=0 → y = 0x01..0x0C one cycle after each err_valid. y_sop on first, y_parity on last 4, y_eop and cw_done on 12th, cw_errs = 0, level returns to 0.
- Correction: same stream, err = 0x55 at index 2 and 0xFF at index 9 → y[2] = 0x03^0x55 = 0x56, y[9] = 0x0A^0xFF = 0xF5, cw_errs = 2.
- Overflow and wrap: ADDR_W=3; write 9 symbols with no reads → level = 8, overflow = 1, 9th symbol dropped. Read 8 → first 8 symbols returned in order; ptrs wrap cleanly on the next codeword.
- Underflow: err_valid = 1, err = 0x3C with level = 0 → underflow = 1, y = 0x3C with y_valid, level stays 0.
- Concurrent traffic: continuous enable and err_valid every cycle with level = 5 → level constant at 5 and y stream matches the input stream delayed. clr asserted mid-codeword → all outputs 0 next cycle, next err_valid flagged as y_sop.
- With RS_CORRECT_STATS_EN: three codewords with 0, 1 and 2 errors → stat_cw = 3, stat_err_cw = 2, stat_sym = 3.

Source files
------------

// File: rtl/rs_correct.sv
// rs_correct: buffers received symbols in a circular delay RAM and XORs in the decoder's error pattern.
// Emits corrected symbols with codeword framing; define RS_CORRECT_STATS_EN for saturating statistics outputs.
module rs_correct #(
    parameter int ADDR_W = 10,
    parameter int NPAR = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        k,
    input  logic [7:0]        x,
    input  logic              enable,
    input  logic [7:0]        err,
    input  logic              err_valid,
    output logic [7:0]        y,
    output logic              y_valid,
    output logic              y_sop,
    output logic              y_eop,
    output logic              y_parity,
    output logic [7:0]        cw_errs,
    output logic              cw_done,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
`ifdef RS_CORRECT_STATS_EN
    ,
    output logic [31:0]       stat_cw,
    output logic [31:0]       stat_err_cw,
    output logic [31:0]       stat_sym
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [7:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [7:0] idx, k_cw, run_cnt, k_eff, cnt_next, rd_data;
    logic full, empty, wr_ok, rd_ok, eop;
    always_comb begin
        full = level == (ADDR_W+1)'(DEPTH);
        empty = level == '0;
        wr_ok = enable & ~full;
        rd_ok = err_valid & ~empty;
        // k is only honoured at the first symbol of a codeword
        k_eff = idx == 8'd0 ? k : k_cw;
        eop = {1'b0, idx} == {1'b0, k_eff} + 9'(NPAR - 1);
        cnt_next = (err != 8'd0 && run_cnt != 8'hFF) ? run_cnt + 8'd1 : run_cnt;
        rd_data = empty ? 8'd0 : mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= x;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            idx <= '0;
            k_cw <= '0;
            run_cnt <= '0;
            y <= '0;
            y_valid <= 1'b0;
            y_sop <= 1'b0;
            y_eop <= 1'b0;
            y_parity <= 1'b0;
            cw_done <= 1'b0;
            cw_errs <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(wr_ok);
            rd_ptr <= rd_ptr + ADDR_W'(rd_ok);
            level <= level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
            overflow <= overflow | (enable & full);
            underflow <= underflow | (err_valid & empty);
            y_valid <= err_valid;
            y_sop <= err_valid & (idx == 8'd0);
            y_eop <= err_valid & eop;
            y_parity <= err_valid & (idx >= k_eff);
            cw_done <= err_valid & eop;
            if (err_valid) begin
                y <= rd_data ^ err;
                if (idx == 8'd0) k_cw <= k;
                idx <= eop ? 8'd0 : idx + 8'd1;
                run_cnt <= eop ? 8'd0 : cnt_next;
                if (eop) cw_errs <= cnt_next;
            end
        end
    end
`ifdef RS_CORRECT_STATS_EN
    logic [32:0] sym_sum;
    always_comb sym_sum = {1'b0, stat_sym} + 33'(cnt_next);
    always_ff @(posedge clk) begin
        if (clr) begin
            stat_cw <= '0;
            stat_err_cw <= '0;
            stat_sym <= '0;
        end else if (err_valid && eop) begin
            if (!(&stat_cw)) stat_cw <= stat_cw + 32'd1;
            if (cnt_next != 8'd0 && !(&stat_err_cw)) stat_err_cw <= stat_err_cw + 32'd1;
            stat_sym <= sym_sum[32] ? '1 : sym_sum[31:0];
        end
    end
`endif
endmodule
